// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: ALU results vs in-order load returns.
// Ports: alu_*, ld_issue*, ld_* in; wr_e/a3/wd3, pc_we/pc_wd, busy_mask, err out.
module writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         alu_valid,
  input  logic [3:0]   alu_rd,
  input  logic [W-1:0] alu_data,
  input  logic         ld_issue,
  input  logic [3:0]   ld_issue_rd,
  output logic         ld_issue_ready,
  input  logic         ld_valid,
  input  logic [W-1:0] ld_data,
  output logic         ld_ready,
  output logic         wr_e,
  output logic [3:0]   a3,
  output logic [W-1:0] wd3,
  output logic         pc_we,
  output logic [W-1:0] pc_wd,
  output logic [15:0]  busy_mask,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [3:0]    tag_mem [DEPTH];
  logic [W-1:0]  dat_mem [DEPTH];
  logic [AW-1:0] tag_wp;
  logic [AW-1:0] tag_rp;
  logic [AW-1:0] dat_wp;
  logic [AW-1:0] dat_rp;
  logic [CW-1:0] tag_cnt;
  logic [CW-1:0] dat_cnt;

  logic [1:0] pend   [16];
  logic [1:0] pend_n [16];

  logic tag_empty;
  logic tag_full;
  logic dat_empty;
  logic dat_full;
  logic tag_push;
  logic dat_push;
  logic ld_sel;
  logic orphan;
  logic bad_issue;
  logic waw;
  logic ovf;
  logic wb_any;

  logic [3:0]   tag_head;
  logic [W-1:0] dat_head;
  logic [3:0]   wb_rd;
  logic [W-1:0] wb_data;

  logic         wr_e_n;
  logic [3:0]   a3_n;
  logic [W-1:0] wd3_n;
  logic         pc_we_n;
  logic [W-1:0] pc_wd_n;

  assign tag_empty = tag_cnt == '0;
  assign dat_empty = dat_cnt == '0;
  assign tag_full  = tag_cnt == FULL;
  assign dat_full  = dat_cnt == FULL;

  assign ld_issue_ready = !tag_full;
  assign ld_ready       = !dat_full;

  assign tag_head = tag_mem[tag_rp];
  assign dat_head = dat_mem[dat_rp];

  assign tag_push  = ld_issue && !tag_full;
  assign bad_issue = ld_issue && tag_full;
  // A load write needs both a tag and its data; any ALU result wins.
  assign ld_sel    = !alu_valid && !tag_empty && !dat_empty;
  // Returned data with no outstanding issue has no destination: drop it.
  assign orphan    = ld_valid && tag_empty;
  assign dat_push  = ld_valid && !tag_empty && !dat_full;
  assign waw       = alu_valid && busy_mask[alu_rd];
  assign wb_any    = alu_valid || ld_sel;

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wp] <= ld_issue_rd;
    if (dat_push) dat_mem[dat_wp] <= ld_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wp  <= '0;
      tag_rp  <= '0;
      tag_cnt <= '0;
      dat_wp  <= '0;
      dat_rp  <= '0;
      dat_cnt <= '0;
    end else begin
      if (tag_push) tag_wp <= tag_wp + AW'(1);
      if (ld_sel)   tag_rp <= tag_rp + AW'(1);
      if (dat_push) dat_wp <= dat_wp + AW'(1);
      if (ld_sel)   dat_rp <= dat_rp + AW'(1);
      if (tag_push && !ld_sel)      tag_cnt <= tag_cnt + CW'(1);
      else if (!tag_push && ld_sel) tag_cnt <= tag_cnt - CW'(1);
      if (dat_push && !ld_sel)      dat_cnt <= dat_cnt + CW'(1);
      else if (!dat_push && ld_sel) dat_cnt <= dat_cnt - CW'(1);
    end
  end

  // Writeback is applied before issue, so same-rd issue+writeback nets to
  // zero and a full counter saturates instead of wrapping.
  always_comb begin
    ovf = 1'b0;
    for (int r = 0; r < 16; r++) begin
      pend_n[r] = pend[r];
      if (ld_sel && tag_head == 4'(r) && pend[r] != 2'd0)
        pend_n[r] = pend[r] - 2'd1;
      if (tag_push && ld_issue_rd == 4'(r)) begin
        if (pend_n[r] == 2'd3) ovf = 1'b1;
        else pend_n[r] = pend_n[r] + 2'd1;
      end
      busy_mask[r] = pend[r] != 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 16; r++) pend[r] <= 2'd0;
    end else begin
      for (int r = 0; r < 16; r++) pend[r] <= pend_n[r];
    end
  end

  always_comb begin
    wb_rd   = '0;
    wb_data = '0;
    wr_e_n  = 1'b0;
    a3_n    = '0;
    wd3_n   = '0;
    pc_we_n = 1'b0;
    pc_wd_n = '0;
    unique case (1'b1)
      alu_valid: begin
        wb_rd   = alu_rd;
        wb_data = alu_data;
      end
      ld_sel: begin
        wb_rd   = tag_head;
        wb_data = dat_head;
      end
      default: ;
    endcase
    // r15 is the PC: redirect instead of writing the register file.
    if (wb_any) begin
      if (wb_rd == 4'hf) begin
        pc_we_n = 1'b1;
        pc_wd_n = wb_data;
      end else begin
        wr_e_n = 1'b1;
        a3_n   = wb_rd;
        wd3_n  = wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_e  <= 1'b0;
      a3    <= '0;
      wd3   <= '0;
      pc_we <= 1'b0;
      pc_wd <= '0;
      err   <= 1'b0;
    end else begin
      wr_e  <= wr_e_n;
      a3    <= a3_n;
      wd3   <= wd3_n;
      pc_we <= pc_we_n;
      pc_wd <= pc_wd_n;
      err   <= err | waw | bad_issue | orphan | ovf;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed cases plus random traffic
// compared every cycle against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         alu_valid = 1'b0;
  logic [3:0]   alu_rd = '0;
  logic [W-1:0] alu_data = '0;
  logic         ld_issue = 1'b0;
  logic [3:0]   ld_issue_rd = '0;
  logic         ld_issue_ready;
  logic         ld_valid = 1'b0;
  logic [W-1:0] ld_data = '0;
  logic         ld_ready;
  logic         wr_e;
  logic [3:0]   a3;
  logic [W-1:0] wd3;
  logic         pc_we;
  logic [W-1:0] pc_wd;
  logic [15:0]  busy_mask;
  logic         err;

  writeback_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .alu_valid(alu_valid),
    .alu_rd(alu_rd),
    .alu_data(alu_data),
    .ld_issue(ld_issue),
    .ld_issue_rd(ld_issue_rd),
    .ld_issue_ready(ld_issue_ready),
    .ld_valid(ld_valid),
    .ld_data(ld_data),
    .ld_ready(ld_ready),
    .wr_e(wr_e),
    .a3(a3),
    .wd3(wd3),
    .pc_we(pc_we),
    .pc_wd(pc_wd),
    .busy_mask(busy_mask),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tag/data FIFOs as queues, per-register pending counts.
  logic [3:0]   m_tags [$];
  logic [W-1:0] m_data [$];
  int           m_cnt  [16];
  bit           m_err  = 1'b0;
  bit           e_wr   = 1'b0;
  bit           e_pc   = 1'b0;
  bit [3:0]     e_a3   = '0;
  bit [W-1:0]   e_wd   = '0;
  bit [W-1:0]   e_pcwd = '0;

  function automatic logic [15:0] m_mask();
    logic [15:0] m;
    m = '0;
    for (int r = 0; r < 16; r++) m[r] = m_cnt[r] > 0;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int nt;
    int nd;
    bit sel;
    logic [3:0] rd;
    logic [W-1:0] d;
    if (!rst_n) begin
      m_tags.delete();
      m_data.delete();
      for (int r = 0; r < 16; r++) m_cnt[r] = 0;
      m_err = 0;
      e_wr = 0;
      e_pc = 0;
      e_a3 = '0;
      e_wd = '0;
      e_pcwd = '0;
    end else begin
      nt = m_tags.size();
      nd = m_data.size();
      e_wr = 0;
      e_pc = 0;
      e_a3 = '0;
      e_wd = '0;
      e_pcwd = '0;
      sel = 0;
      rd = '0;
      d = '0;
      if (alu_valid) begin
        if (m_cnt[alu_rd] > 0) m_err = 1;
        rd = alu_rd;
        d = alu_data;
        sel = 1;
      end else if (nt > 0 && nd > 0) begin
        rd = m_tags.pop_front();
        d = m_data.pop_front();
        if (m_cnt[rd] > 0) m_cnt[rd]--;
        sel = 1;
      end
      if (sel) begin
        if (rd == 4'hf) begin
          e_pc = 1;
          e_pcwd = d;
        end else begin
          e_wr = 1;
          e_a3 = rd;
          e_wd = d;
        end
      end
      if (ld_issue) begin
        if (nt < DEPTH) begin
          m_tags.push_back(ld_issue_rd);
          if (m_cnt[ld_issue_rd] == 3) m_err = 1;
          else m_cnt[ld_issue_rd]++;
        end else begin
          m_err = 1;
        end
      end
      if (ld_valid) begin
        if (nt == 0) m_err = 1;
        else if (nd < DEPTH) m_data.push_back(ld_data);
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_e", {31'd0, wr_e}, {31'd0, e_wr});
    if (e_wr) begin
      chk("a3", {28'd0, a3}, {28'd0, e_a3});
      chk("wd3", wd3, e_wd);
    end
    chk("pc_we", {31'd0, pc_we}, {31'd0, e_pc});
    if (e_pc) chk("pc_wd", pc_wd, e_pcwd);
    chk("busy_mask", {16'd0, busy_mask}, {16'd0, m_mask()});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("ld_issue_ready", {31'd0, ld_issue_ready},
        {31'd0, m_tags.size() < DEPTH});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_data.size() < DEPTH});
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit got;
    int n;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_e", {31'd0, wr_e}, 32'd0);
    chk("rst_a3", {28'd0, a3}, 32'd0);
    chk("rst_wd3", wd3, 32'd0);
    chk("rst_pc_we", {31'd0, pc_we}, 32'd0);
    chk("rst_pc_wd", pc_wd, 32'd0);
    chk("rst_busy", {16'd0, busy_mask}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_issue_rdy", {31'd0, ld_issue_ready}, 32'd1);
    chk("rst_ld_rdy", {31'd0, ld_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU write and its pulse width
    alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
    cyc();
    alu_valid = 0;
    chk("alu_wr_e", {31'd0, wr_e}, 32'd1);
    chk("alu_a3", {28'd0, a3}, 32'd3);
    chk("alu_wd3", wd3, 32'hDEADBEEF);
    cyc();
    chk("alu_pulse", {31'd0, wr_e}, 32'd0);

    // Single load
    ld_issue = 1; ld_issue_rd = 5;
    cyc();
    ld_issue = 0;
    chk("ld_busy", {16'd0, busy_mask}, 32'h0020);
    cyc();
    ld_valid = 1; ld_data = 32'h12345678;
    cyc();
    ld_valid = 0;
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      cyc();
      if (wr_e) begin
        got = 1;
        chk("ld_a3", {28'd0, a3}, 32'd5);
        chk("ld_wd3", wd3, 32'h12345678);
        chk("ld_busy_clr", {16'd0, busy_mask}, 32'd0);
      end
    end
    chk("ld_wb_seen", {31'd0, got}, 32'd1);

    // ALU priority over a ready load write
    ld_issue = 1; ld_issue_rd = 2;
    cyc();
    ld_issue = 0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 7; alu_data = 32'hA0 + i;
      ld_valid = (i == 0); ld_data = 32'h2222;
      cyc();
      chk("prio_alu_a3", {28'd0, a3}, 32'd7);
      chk("prio_alu_wd3", wd3, 32'hA0 + i);
    end
    alu_valid = 0; ld_valid = 0;
    cyc();
    chk("prio_ld_a3", {28'd0, a3}, 32'd2);
    chk("prio_ld_wd3", wd3, 32'h2222);

    // PC redirect
    alu_valid = 1; alu_rd = 15; alu_data = 32'h100;
    cyc();
    alu_valid = 0;
    chk("pc_we", {31'd0, pc_we}, 32'd1);
    chk("pc_wd", pc_wd, 32'h100);
    chk("pc_no_wr", {31'd0, wr_e}, 32'd0);
    cyc();
    chk("pc_pulse", {31'd0, pc_we}, 32'd0);

    // Fill the tag queue, then overflow it
    for (int i = 1; i <= 4; i++) begin
      ld_issue = 1; ld_issue_rd = 4'(i);
      cyc();
    end
    ld_issue = 0;
    chk("full_rdy", {31'd0, ld_issue_ready}, 32'd0);
    chk("full_busy", {16'd0, busy_mask}, 32'h001E);
    chk("full_err0", {31'd0, err}, 32'd0);
    ld_issue = 1; ld_issue_rd = 6;
    cyc();
    ld_issue = 0;
    chk("ovf_err", {31'd0, err}, 32'd1);
    chk("ovf_busy", {16'd0, busy_mask}, 32'h001E);
    n = 0;
    for (int k = 0; k < 12 && n < 4; k++) begin
      ld_valid = k < 4;
      ld_data = 32'h1001 + k;
      cyc();
      if (wr_e) begin
        chk("drain_a3", {28'd0, a3}, n + 1);
        chk("drain_wd3", wd3, 32'h1001 + n);
        n++;
      end
    end
    ld_valid = 0;
    chk("drain_count", n, 4);

    // Async reset with loads pending
    ld_issue = 1; ld_issue_rd = 8;
    alu_valid = 1; alu_rd = 9; alu_data = 32'h55;
    cyc();
    ld_issue_rd = 10;
    cyc();
    ld_issue = 0; alu_valid = 0;
    chk("pre_rst_wr", {31'd0, wr_e}, 32'd1);
    chk("pre_rst_busy", {16'd0, busy_mask}, 32'h0500);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wr_e", {31'd0, wr_e}, 32'd0);
    chk("arst_busy", {16'd0, busy_mask}, 32'd0);
    chk("arst_rdy", {31'd0, ld_issue_ready}, 32'd1);
    chk("arst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Random traffic; even segments avoid protocol violations
    for (int seg = 0; seg < 8; seg++) begin
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int c = 0; c < 250; c++) begin
        alu_valid = $urandom_range(99) < ((seg % 2) ? 30 : 55);
        alu_rd = 4'($urandom_range(15));
        alu_data = $urandom;
        ld_issue = $urandom_range(99) < 40;
        ld_issue_rd = 4'($urandom_range(15));
        ld_valid = $urandom_range(99) < 45;
        ld_data = $urandom;
        if (seg % 2 == 0) begin
          if (m_cnt[alu_rd] > 0) alu_valid = 0;
          if (m_tags.size() == 0) ld_valid = 0;
          if (m_tags.size() >= DEPTH) ld_issue = 0;
        end
        cyc();
      end
      alu_valid = 0; ld_issue = 0; ld_valid = 0;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer side of the register-file write port: merges single-cycle ALU results and in-order, variable-latency load returns into the single write port (`a3`/`wr_e`/`wd3`).
- Keeps a pending-destination scoreboard that decode uses for load-use stalls.
- Steers r15 destinations to a PC-redirect port instead of the register file.
- Sits between the execute/memory stages and the register file.

Parameters:
- DEPTH, 4, entries in both the load tag queue and the load data queue (power of two, >=2)
- W, 32, datapath width

Ports:
- clk  in  1  system clock, rising-edge logic
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  4  ALU destination register
- alu_data  in  W  ALU result
- ld_issue  in  1  load issued to memory; records ld_issue_rd
- ld_issue_rd  in  4  load destination register
- ld_issue_ready  out  1  tag queue not full
- ld_valid  in  1  load data returning (in issue order)
- ld_data  in  W  returned load data
- ld_ready  out  1  data queue not full
- wr_e  out  1  register-file write enable
- a3  out  4  register-file write address (never 15 while wr_e=1)
- wd3  out  W  register-file write data
- pc_we  out  1  PC redirect strobe
- pc_wd  out  W  PC redirect value
- busy_mask  out  16  bit n set = load to Rn outstanding
- err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_n=0, async): wr_e=0, a3=0, wd3=0, pc_we=0, pc_wd=0, busy_mask=0, err=0, both queues empty, ld_issue_ready=1, ld_ready=1.
- Tag queue: FIFO of 4-bit rd.
  - Push on ld_issue && ld_issue_ready.
  - Pop when its head is written back.
- Data queue: FIFO of W-bit data.
  - Push on ld_valid && ld_ready.
  - ld_ready = !full.
- Load returns with an empty tag queue (no outstanding issue) set err; the data is dropped.
- Arbitration each cycle, one write slot:
  - Priority 1: alu_valid.
  - Priority 2: load write, when both queues are non-empty. It pairs the data-queue head with the tag-queue head and pops both.
  - A pending load write waits while alu_valid=1. No starvation guarantee is required; upstream bubbles drain it.
- Output timing: selected write is registered and appears on wr_e/a3/wd3 the next rising edge, 1-cycle latency. The register file captures it on the following negedge.
- Destination 15: the selected write drives pc_we=1 and pc_wd=data instead of wr_e. It has the same 1-cycle latency, and wr_e=0 that cycle.
- Outputs are pulses, deasserted in any cycle with no selected write.
- busy_mask:
  - Bit rd sets on ld_issue acceptance.
  - The bit clears when that tag is written back.
  - Two outstanding loads to the same rd are tracked with a per-register 2-bit pending counter; the bit stays set while the count is >0.
  - Issue and writeback of the same rd in the same cycle leave the count unchanged.
- Violations that set err (cleared only by reset):
  - alu_valid with alu_rd whose busy bit is set (WAW against a pending load). The ALU write still proceeds.
  - ld_issue while ld_issue_ready=0. The issue is ignored.
  - Pending counter overflow.
- Simultaneous push and pop on a full queue:
  - Legal only for the data queue when a load write is selected that cycle.
  - ld_ready is computed from the registered count only, so it does not reflect same-cycle pops.
- Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- Reset asserted mid-operation discards all queued tags and data and clears the scoreboard immediately.

Test Plan:
- ALU write: alu_valid=1, alu_rd=3, alu_data=0xDEADBEEF -> next cycle wr_e=1, a3=3, wd3=0xDEADBEEF; following cycle wr_e=0.
- Load path: ld_issue rd=5 -> busy_mask=0x0020.
  - Two cycles later ld_valid with data 0x12345678 and no ALU -> wr_e=1, a3=5, wd3=0x12345678 next cycle.
  - busy_mask=0 after that write.
- Priority: load data queued for rd=2 while alu_valid is held 3 cycles (rd=7) -> three ALU writes to R7, then the R2 write on the 4th output cycle.
- PC redirect: alu_valid, alu_rd=15, data=0x00000100 -> pc_we=1, pc_wd=0x100, wr_e=0.
- Full and overflow: issue 4 loads (rd=1,2,3,4) -> ld_issue_ready=0. A 5th issue sets err=1 and the queue is unchanged. Returning 4 data words then produces writes to R1..R4 in order.
- Async reset: assert rst_n=0 mid-stream with 2 loads pending -> wr_e=0, busy_mask=0, ld_issue_ready=1 without a clock edge.
